// File: rtl/wb_if.sv
// Writeback stage bus: upstream result handshake, data-memory read response,
// and register-file write port, bundled for the writeback_stage.
interface wb_if #(
    parameter int XLEN = 32
);
    // Handshake: a result transfers on a rising clk edge where in_valid and in_ready
    // are both 1. in_ready depends only on stage state, never on in_valid.
    // mem_rvalid is a 1-cycle pulse and carries no ready.
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic            in_rd_en;
    logic            in_is_load;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_alu_result;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            rd_we;
    logic [4:0]      writeReg;
    logic [XLEN-1:0] writeData;
    logic            misalign;
    logic            load_timeout;

    modport master (
        output in_valid, in_rd, in_rd_en, in_is_load, in_funct3, in_alu_result,
        output mem_rvalid, mem_rdata,
        input  in_ready, rd_we, writeReg, writeData, misalign, load_timeout
    );

    modport slave (
        input  in_valid, in_rd, in_rd_en, in_is_load, in_funct3, in_alu_result,
        input  mem_rvalid, mem_rdata,
        output in_ready, rd_we, writeReg, writeData, misalign, load_timeout
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results and aligned loads into the register file.
// Optional macro WB_FWD_EN adds forwarding outputs (fwd_valid/fwd_rd/fwd_data) and stall_load.
module writeback_stage #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    wb_if.slave             bus,
`ifdef WB_FWD_EN
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data,
    output logic            stall_load,
`endif
    output logic            dbg_state
);
    typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic              ld_en_q, ld_en_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic              rd_we_d, misalign_d, timeout_d;
    logic [4:0]        wreg_d;
    logic [XLEN-1:0]   wdata_d;
    logic [2:0]        f3_norm;
    logic              mis;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;

    assign bus.in_ready = (state_q == IDLE);
    assign dbg_state    = state_q;

    // Unsupported load encodings collapse to LW, including for the alignment check.
    always_comb begin
        f3_norm = bus.in_funct3;
        if (!(bus.in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            f3_norm = 3'b010;
        mis = 1'b0;
        case (f3_norm)
            3'b001, 3'b101: mis = bus.in_alu_result[0];
            3'b010:         mis = (bus.in_alu_result[1:0] != 2'b00);
            default:        mis = 1'b0;
        endcase
    end

    always_comb begin
        ld_byte = bus.mem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half = ld_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ld_rd_d    = ld_rd_q;
        ld_en_d    = ld_en_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        rd_we_d    = 1'b0;
        misalign_d = 1'b0;
        timeout_d  = 1'b0;
        wreg_d     = bus.writeReg;
        wdata_d    = bus.writeData;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (!bus.in_is_load) begin
                        rd_we_d = bus.in_rd_en && (bus.in_rd != 5'd0);
                        if (rd_we_d) begin
                            wreg_d  = bus.in_rd;
                            wdata_d = bus.in_alu_result;
                        end
                    end else begin
                        ld_rd_d  = bus.in_rd;
                        ld_en_d  = bus.in_rd_en;
                        ld_f3_d  = f3_norm;
                        ld_off_d = bus.in_alu_result[1:0];
                        cnt_d    = '0;
                        if (mis) misalign_d = 1'b1;
                        else     state_d    = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                // Data arriving on the final counted cycle still retires the load.
                if (bus.mem_rvalid) begin
                    rd_we_d = ld_en_q && (ld_rd_q != 5'd0);
                    if (rd_we_d) begin
                        wreg_d  = ld_rd_q;
                        wdata_d = ld_data;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            ld_rd_q          <= '0;
            ld_en_q          <= 1'b0;
            ld_f3_q          <= '0;
            ld_off_q         <= '0;
            bus.rd_we        <= 1'b0;
            bus.misalign     <= 1'b0;
            bus.load_timeout <= 1'b0;
            bus.writeReg     <= '0;
            bus.writeData    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ld_rd_q          <= ld_rd_d;
            ld_en_q          <= ld_en_d;
            ld_f3_q          <= ld_f3_d;
            ld_off_q         <= ld_off_d;
            bus.rd_we        <= rd_we_d;
            bus.misalign     <= misalign_d;
            bus.load_timeout <= timeout_d;
            bus.writeReg     <= wreg_d;
            bus.writeData    <= wdata_d;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid  = bus.rd_we;
    assign fwd_rd     = bus.writeReg;
    assign fwd_data   = bus.writeData;
    assign stall_load = (state_q == LOAD_WAIT);
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU writes, load extension, misalignment,
// timeout boundary, stray responses and reset during a pending load.
module tb_writeback_stage;
    logic clk;
    logic rst;
    logic dbg_state;
    int   checks;
    int   failures;

    wb_if #(.XLEN(32)) bus ();

`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        stall_load;
`endif

    writeback_stage #(.XLEN(32), .TIMEOUT(255), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef WB_FWD_EN
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .stall_load (stall_load),
`endif
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one result for exactly one edge; returns at the negedge after it.
    task automatic issue(input logic is_load, input logic [4:0] rd, input logic rd_en,
                         input logic [2:0] f3, input logic [31:0] val);
        bus.in_valid      = 1'b1;
        bus.in_is_load    = is_load;
        bus.in_rd         = rd;
        bus.in_rd_en      = rd_en;
        bus.in_funct3     = f3;
        bus.in_alu_result = val;
        @(negedge clk);
        bus.in_valid      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL reset_rd_we got=%0b exp=0", bus.rd_we); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.writeData !== 32'h0) begin failures++; $display("FAIL reset_writeData got=%h exp=0", bus.writeData); end
        checks++; if (bus.writeReg !== 5'd0) begin failures++; $display("FAIL reset_writeReg got=%0d exp=0", bus.writeReg); end
        checks++; if ({bus.misalign, bus.load_timeout} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {bus.misalign, bus.load_timeout}); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_write();
        issue(1'b0, 5'd5, 1'b1, 3'b000, 32'hDEADBEEF);
        checks++; if (bus.rd_we !== 1'b1) begin failures++; $display("FAIL alu_rd_we got=%0b exp=1", bus.rd_we); end
        checks++; if (bus.writeReg !== 5'd5) begin failures++; $display("FAIL alu_writeReg got=%0d exp=5", bus.writeReg); end
        checks++; if (bus.writeData !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_writeData got=%h exp=deadbeef", bus.writeData); end
`ifdef WB_FWD_EN
        checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin failures++; $display("FAIL alu_fwd got=%0b/%0d/%h exp=1/5/deadbeef", fwd_valid, fwd_rd, fwd_data); end
`endif
        @(negedge clk);
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL alu_pulse got=%0b exp=0", bus.rd_we); end
        issue(1'b0, 5'd0, 1'b1, 3'b000, 32'h11111111);
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL alu_x0_rd_we got=%0b exp=0", bus.rd_we); end
        checks++; if (bus.writeData !== 32'hDEADBEEF) begin failures++; $display("FAIL alu_x0_hold got=%h exp=deadbeef", bus.writeData); end
        issue(1'b0, 5'd9, 1'b0, 3'b000, 32'h22222222);
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL alu_rden0_rd_we got=%0b exp=0", bus.rd_we); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  rds  [3];
        logic [31:0] vals [3];
        rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd31;
        vals[0] = 32'hA5A50001; vals[1] = 32'h5A5A0002; vals[2] = 32'h0000FFFF;
        bus.in_is_load = 1'b0;
        bus.in_rd_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid      = 1'b1;
            bus.in_rd         = rds[i];
            bus.in_alu_result = vals[i];
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, bus.in_ready); end
            checks++; if ({bus.rd_we, bus.writeReg, bus.writeData} !== {1'b1, rds[i], vals[i]})
                begin failures++; $display("FAIL b2b_write[%0d] got=%0b/%0d/%h exp=1/%0d/%h", i, bus.rd_we, bus.writeReg, bus.writeData, rds[i], vals[i]); end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // Load retired by a response 'delay' cycles after acceptance.
    task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input int delay, input logic [4:0] rd,
                            input logic [31:0] exp);
        issue(1'b1, rd, 1'b1, f3, addr);
        for (int i = 1; i < delay; i++) begin
            checks++; if ({bus.in_ready, bus.rd_we} !== 2'b00) begin failures++; $display("FAIL %s_wait[%0d] ready/we got=%b exp=00", name, i, {bus.in_ready, bus.rd_we}); end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.rd_we, bus.writeReg} !== {1'b1, rd}) begin failures++; $display("FAIL %s_we got=%0b/%0d exp=1/%0d", name, bus.rd_we, bus.writeReg, rd); end
        checks++; if (bus.writeData !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, bus.writeData, exp); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s_ready_after got=%0b exp=1", name, bus.in_ready); end
    endtask

    task automatic test_load_extend();
        run_load("lb",  3'b000, 32'h1001, 32'h12348000, 3, 5'd10, 32'hFFFFFF80);
        run_load("lbu", 3'b100, 32'h1001, 32'h12348000, 3, 5'd11, 32'h00000080);
        run_load("lhu", 3'b101, 32'h1002, 32'h12348000, 2, 5'd12, 32'h00001234);
        run_load("lh",  3'b001, 32'h1002, 32'h80001234, 1, 5'd13, 32'hFFFF8000);
        run_load("lb3", 3'b000, 32'h1003, 32'h7F000000, 2, 5'd14, 32'h0000007F);
        run_load("lw",  3'b010, 32'h1000, 32'hCAFEF00D, 4, 5'd15, 32'hCAFEF00D);
        run_load("f3x", 3'b111, 32'h1004, 32'h87654321, 1, 5'd16, 32'h87654321);
    endtask

    task automatic test_misalign();
        issue(1'b1, 5'd3, 1'b1, 3'b010, 32'h1002);
        checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL mis_lw_pulse got=%0b exp=1", bus.misalign); end
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL mis_lw_rd_we got=%0b exp=0", bus.rd_we); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mis_lw_ready got=%0b exp=1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL mis_pulse_end got=%0b exp=0", bus.misalign); end
        issue(1'b1, 5'd3, 1'b1, 3'b101, 32'h1003);
        checks++; if (bus.misalign !== 1'b1) begin failures++; $display("FAIL mis_lhu_pulse got=%0b exp=1", bus.misalign); end
        issue(1'b1, 5'd3, 1'b1, 3'b001, 32'h1002);
        checks++; if (bus.misalign !== 1'b0) begin failures++; $display("FAIL mis_lh_aligned got=%0b exp=0", bus.misalign); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_0001;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b1, 5'd7, 1'b1, 3'b010, 32'h2000);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (bus.load_timeout === 1'b1) break;
        end
        checks++; if (n !== 256) begin failures++; $display("FAIL timeout_cycles got=%0d exp=256", n); end
        checks++; if ({bus.rd_we, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL timeout_we_ready got=%b exp=01", {bus.rd_we, bus.in_ready}); end
        @(negedge clk);
        checks++; if (bus.load_timeout !== 1'b0) begin failures++; $display("FAIL timeout_pulse_end got=%0b exp=0", bus.load_timeout); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h55555555;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.rd_we, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL stray_rvalid got=%b exp=01", {bus.rd_we, bus.in_ready}); end
    endtask

    task automatic test_timeout_boundary();
        issue(1'b1, 5'd8, 1'b1, 3'b010, 32'h3000);
        repeat (255) @(negedge clk);
        checks++; if ({bus.in_ready, bus.load_timeout} !== 2'b00) begin failures++; $display("FAIL edge_still_waiting got=%b exp=00", {bus.in_ready, bus.load_timeout}); end
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BADC0DE;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if ({bus.rd_we, bus.load_timeout} !== 2'b10) begin failures++; $display("FAIL edge_data_wins got=%b exp=10", {bus.rd_we, bus.load_timeout}); end
        checks++; if (bus.writeData !== 32'h0BADC0DE) begin failures++; $display("FAIL edge_data got=%h exp=0badc0de", bus.writeData); end
    endtask

    task automatic test_reset_mid_load();
        issue(1'b1, 5'd20, 1'b1, 3'b000, 32'h1001);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12348000;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL rstmid_rd_we got=%0b exp=0", bus.rd_we); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%0b exp=1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.rd_we !== 1'b0) begin failures++; $display("FAIL rstmid_late got=%0b exp=0", bus.rd_we); end
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        rst               = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_rd         = '0;
        bus.in_rd_en      = 1'b0;
        bus.in_is_load    = 1'b0;
        bus.in_funct3     = '0;
        bus.in_alu_result = '0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        @(negedge clk);
        test_reset();
        test_alu_write();
        test_back_to_back();
        test_load_extend();
        test_misalign();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
